// File: rtl/fifo_pack_reader.sv
// fifo_pack_reader: drains a FIFO read port and packs PACK consecutive words into one wide valid/ready word.
// Latency: read strobe -> capture 1 cycle; completed pack register -> m_valid on the following cycle.
// Backpressure: m_ready low holds m_data/m_keep; packing continues up to PACK words, then reads stop.
module fifo_pack_reader #(
  parameter int WIDTH = 8,
  parameter int PACK  = 4
) (
  input  logic                  read_clk,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [WIDTH-1:0]      fifo_data,
  output logic                  fifo_read_en,
  input  logic                  flush,
  output logic [WIDTH*PACK-1:0] m_data,
  output logic [PACK-1:0]       m_keep,
  output logic                  m_valid,
  input  logic                  m_ready
);

  localparam int            CW   = $clog2(PACK) + 1;
  localparam logic [CW-1:0] FULL = CW'(PACK);

  logic [WIDTH*PACK-1:0] r_pack;
  logic [CW-1:0]         r_fill;
  logic                  r_inflight;
  logic                  r_flush_pending;
  logic [WIDTH*PACK-1:0] r_m_data;
  logic [PACK-1:0]       r_m_keep;
  logic                  r_m_valid;

  logic [CW-1:0]         w_occupied;
  logic                  w_read;
  logic                  w_complete;
  logic                  w_free;
  logic                  w_handoff;
  logic [PACK-1:0]       w_keep;
  logic [WIDTH*PACK-1:0] w_pack_masked;

  // Read gating, hand-off decision, and the lane mask of the word about to leave
  always_comb begin
    w_occupied    = r_fill + CW'(r_inflight);
    w_read        = !fifo_empty && !r_flush_pending && (w_occupied < FULL);
    w_complete    = (r_fill == FULL) || (r_flush_pending && (r_fill != '0) && !r_inflight);
    w_free        = !r_m_valid || m_ready;
    w_handoff     = w_complete && w_free;
    w_keep        = '0;
    w_pack_masked = '0;
    for (int i = 0; i < PACK; i++) begin
      // Lanes at or beyond the fill count may hold stale words from the previous pack.
      w_keep[i] = (CW'(i) < r_fill);
      if (w_keep[i]) begin
        w_pack_masked[i*WIDTH +: WIDTH] = r_pack[i*WIDTH +: WIDTH];
      end
    end
  end

  // Pack register, fill count, in-flight tracking and flush request
  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      r_pack          <= '0;
      r_fill          <= '0;
      r_inflight      <= 1'b0;
      r_flush_pending <= 1'b0;
    end else begin
      r_inflight <= w_read;
      // A capture cannot coincide with a hand-off: fill+inflight never exceeds PACK.
      if (w_handoff) begin
        r_fill <= '0;
      end else if (r_inflight) begin
        r_fill <= r_fill + CW'(1);
      end
      for (int i = 0; i < PACK; i++) begin
        if (r_inflight && (r_fill == CW'(i))) begin
          r_pack[i*WIDTH +: WIDTH] <= fifo_data;
        end
      end
      // A flush landing on the hand-off cycle refers to the word already leaving.
      if (w_handoff) begin
        r_flush_pending <= 1'b0;
      end else if (flush && (w_occupied != '0)) begin
        r_flush_pending <= 1'b1;
      end
    end
  end

  // Output register: loads on hand-off, holds while stalled, drops valid on acceptance
  always_ff @(posedge read_clk or posedge rst) begin
    if (rst) begin
      r_m_data  <= '0;
      r_m_keep  <= '0;
      r_m_valid <= 1'b0;
    end else if (w_handoff) begin
      r_m_data  <= w_pack_masked;
      r_m_keep  <= w_keep;
      r_m_valid <= 1'b1;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign fifo_read_en = w_read;
  assign m_data       = r_m_data;
  assign m_keep       = r_m_keep;
  assign m_valid      = r_m_valid;

endmodule

// File: tb/tb_fifo_pack_reader.sv
// tb_fifo_pack_reader: drives fifo_pack_reader from a queue-based FIFO and checks every accepted word
// against a word-grouping model built from the order of read strobes and flush requests.
module tb_fifo_pack_reader;
  localparam int W = 8;
  localparam int P = 4;

  typedef struct {
    logic [W*P-1:0] d;
    logic [P-1:0]   k;
  } exp_t;

  logic           read_clk = 1'b0;
  logic           rst = 1'b1;
  logic           fifo_empty = 1'b1;
  logic [W-1:0]   fifo_data = '0;
  logic           fifo_read_en;
  logic           flush = 1'b0;
  logic [W*P-1:0] m_data;
  logic [P-1:0]   m_keep;
  logic           m_valid;
  logic           m_ready = 1'b0;

  fifo_pack_reader #(.WIDTH(W), .PACK(P)) dut (
    .read_clk(read_clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read_en(fifo_read_en), .flush(flush), .m_data(m_data), .m_keep(m_keep),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 read_clk = ~read_clk;

  int n_chk = 0;
  int n_pass = 0;

  logic [W-1:0] fq[$];    // FIFO contents
  logic [W-1:0] grp[$];   // words strobed since the last closed output word
  exp_t         expq[$];  // closed output words awaiting acceptance
  logic         gate = 1'b0;

  int             nstrobe = 0, first_s = 0, last_s = 0, cyc_n = 0;
  int             acc_n = 0, ccyc = 0, hs_prev = 0, hs_last = 0;
  logic [W*P-1:0] last_d = '0;
  logic [P-1:0]   last_k = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic close_grp();
    exp_t e;
    e.d = '0;
    e.k = '0;
    for (int i = 0; i < grp.size(); i++) begin
      e.d[i*W +: W] = grp[i];
      e.k[i]        = 1'b1;
    end
    expq.push_back(e);
    grp.delete();
  endtask

  // Model: words group in strobe order; PACK words close a group, a flush closes a non-empty one
  // (including a word strobed in the flush cycle itself).
  task automatic model_step(input logic re, input logic fl, input logic [W-1:0] w);
    logic f;
    f = fl && (grp.size() > 0);
    if (re) grp.push_back(w);
    if (grp.size() == P) close_grp();
    if (f && grp.size() > 0) close_grp();
  endtask

  // One clock cycle; entered and left at posedge+1.
  task automatic cyc();
    logic re, fl;
    logic [W-1:0] w;
    fifo_empty = (fq.size() == 0) || gate;
    #3;
    re = fifo_read_en;
    fl = flush;
    w  = '0;
    if (re) begin
      chk("read_while_empty", fifo_empty, 0);
      if (fq.size() > 0) w = fq.pop_front();
      if (nstrobe == 0) first_s = cyc_n;
      last_s = cyc_n;
      nstrobe++;
    end
    if (!rst) model_step(re, fl, w);
    @(posedge read_clk);
    #1;
    if (re) fifo_data = w;
    cyc_n++;
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  // Compare process: every accepted word against the model, stability during stalls, zeros in reset
  logic           stall_prev = 1'b0;
  logic [W*P-1:0] pd;
  logic [P-1:0]   pk;
  always @(negedge read_clk) begin : cmp
    exp_t e;
    ccyc++;
    if (rst) begin
      chk("reset_m_valid", m_valid, 0);
      chk("reset_m_data", m_data, 0);
      chk("reset_m_keep", m_keep, 0);
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, pd);
        chk("stall_keep", m_keep, pk);
      end
      if (m_valid && m_ready) begin
        chk("word_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("word_data", m_data, e.d);
          chk("word_keep", m_keep, e.k);
        end
        acc_n++;
        last_d  = m_data;
        last_k  = m_keep;
        hs_prev = hs_last;
        hs_last = ccyc;
      end
      stall_prev = m_valid && !m_ready;
      pd = m_data;
      pk = m_keep;
    end
  end

  initial begin
    int acc0, guard;
    // Reset state
    #12;
    chk("rst_read_en", fifo_read_en, 0);
    chk("rst_valid", m_valid, 0);
    @(posedge read_clk);
    #1;
    rst = 1'b0;

    // Four words, ready high: four back-to-back strobes, one full word
    m_ready = 1'b1;
    acc0 = acc_n;
    nstrobe = 0;
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    run(12);
    chk("t1_strobes", nstrobe, 4);
    chk("t1_consecutive", last_s - first_s, 3);
    chk("t1_words", acc_n - acc0, 1);
    chk("t1_data", last_d, 32'h44332211);
    chk("t1_keep", last_k, 4'b1111);
    chk("t1_valid_drops", m_valid, 0);

    // Stall with eight words queued, then release: gap-free second word
    m_ready = 1'b0;
    acc0 = acc_n;
    nstrobe = 0;
    for (int i = 1; i <= 8; i++) fq.push_back(W'(i));
    run(16);
    chk("t2_strobes", nstrobe, 8);
    chk("t2_held_valid", m_valid, 1);
    chk("t2_held_data", m_data, 32'h04030201);
    m_ready = 1'b1;
    run(10);
    chk("t2_words", acc_n - acc0, 2);
    chk("t2_gapless", hs_last - hs_prev, 1);
    chk("t2_second", last_d, 32'h08070605);

    // Partial word by flush; reads stay blocked while the flush is pending
    acc0 = acc_n;
    fq.push_back(8'hA1); fq.push_back(8'hA2); fq.push_back(8'hA3);
    run(8);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    fq.push_back(8'hB1);
    nstrobe = 0;
    cyc();
    chk("t3_blocked", nstrobe, 0);
    run(8);
    chk("t3_words", acc_n - acc0, 1);
    chk("t3_data", last_d, 32'h00A3A2A1);
    chk("t3_keep", last_k, 4'b0111);
    fq.push_back(8'hB2); fq.push_back(8'hB3); fq.push_back(8'hB4);
    run(10);
    chk("t3_next", last_d, 32'hB4B3B2B1);

    // Flush with nothing packed or in flight is ignored
    acc0 = acc_n;
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    run(6);
    chk("t4_no_word", acc_n - acc0, 0);
    chk("t4_no_valid", m_valid, 0);
    fq.push_back(8'hE1); fq.push_back(8'hE2); fq.push_back(8'hE3); fq.push_back(8'hE4);
    run(10);
    chk("t4_full_after", last_d, 32'hE4E3E2E1);
    chk("t4_keep_after", last_k, 4'b1111);

    // Flush while one read is in flight: that word is captured, then emitted alone
    fq.push_back(8'hC1);
    cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    run(8);
    chk("t5_data", last_d, 32'h000000C1);
    chk("t5_keep", last_k, 4'b0001);

    // Empty toggling every other cycle
    acc0 = acc_n;
    for (int i = 0; i < 12; i++) fq.push_back(W'(8'h21 + i));
    for (int i = 0; i < 60; i++) begin
      gate = ~gate;
      cyc();
    end
    gate = 1'b0;
    chk("t6_words", acc_n - acc0, 3);
    chk("t6_last", last_d, 32'h2C2B2A29);

    // Asynchronous reset with a stalled output word and two words packed
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) fq.push_back(W'(8'h51 + i));
    run(14);
    chk("t7_pre_valid", m_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t7_async_valid", m_valid, 0);
    chk("t7_async_data", m_data, 0);
    chk("t7_async_keep", m_keep, 0);
    chk("t7_async_read", fifo_read_en, 0);
    fq.delete();
    grp.delete();
    expq.delete();
    @(posedge read_clk);
    #1;
    run(2);
    rst = 1'b0;
    acc0 = acc_n;
    m_ready = 1'b1;
    fq.push_back(8'hD1); fq.push_back(8'hD2); fq.push_back(8'hD3); fq.push_back(8'hD4);
    run(12);
    chk("t7_words", acc_n - acc0, 1);
    chk("t7_data", last_d, 32'hD4D3D2D1);

    // Randomised traffic, ready, empty gating and flushes
    for (int i = 0; i < 600; i++) begin
      if (($urandom % 3) == 0 && fq.size() < 16) fq.push_back(W'($urandom));
      m_ready = (($urandom % 4) != 0);
      gate    = (($urandom % 4) == 0);
      flush   = (($urandom % 16) == 0);
      cyc();
      flush = 1'b0;
    end

    // Drain everything out
    gate = 1'b0;
    m_ready = 1'b1;
    guard = 0;
    while (fq.size() > 0 && guard < 200) begin
      cyc();
      guard++;
    end
    chk("drain_fifo_empty", fq.size(), 0);
    run(10);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    run(20);
    chk("drain_all_words", expq.size(), 0);
    chk("drain_valid_low", m_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
